// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/hold controller with a data-bus wait FSM and a bus timeout.
// Optional stall-cycle counter is built only when STALL_PERF_EN is defined.
module pipe_stall_ctrl #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        mem_req,
    input  logic        bus_ack,
    output logic        bus_req,
    output logic        bus_err,
    output logic [5:0]  stall,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } state_t;

    localparam logic [5:0] HOLD_MEM = 6'b011111;
    localparam logic [5:0] HOLD_EX  = 6'b001111;
    localparam logic [5:0] HOLD_ID  = 6'b000111;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic [7:0] wait_cnt_inc;
    logic       bus_req_nxt;
    logic       bus_err_nxt;
    logic       mem_stall;

    assign wait_cnt_inc = wait_cnt + 8'd1;

    // State, wait counter and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            bus_req  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            bus_req  <= bus_req_nxt;
            bus_err  <= bus_err_nxt;
        end
    end

    // Next state: bus_ack is only meaningful while waiting on the bus.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        bus_err_nxt  = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_req) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (bus_ack) begin
                    state_nxt = MEM_DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt_inc;
                    if (wait_cnt_inc == TIMEOUT_CYCLES) begin
                        state_nxt   = MEM_DONE;
                        bus_err_nxt = 1'b1;
                    end
                end
            end
            MEM_DONE: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        bus_req_nxt = (state_nxt == MEM_WAIT);
    end

    assign mem_stall = ((state == RUN) && mem_req) || (state == MEM_WAIT);

    // Hold mask: the deepest requesting stage wins, lower requests are masked.
    always_comb begin
        stall = 6'b000000;
        if (!rst) begin
            stall = 6'b000000;
        end else if (mem_stall) begin
            stall = HOLD_MEM;
        end else if (stallreq_ex) begin
            stall = HOLD_EX;
        end else if (stallreq_id) begin
            stall = HOLD_ID;
        end
    end

`ifdef STALL_PERF_EN
    logic [15:0] cnt_q;

    // Saturating count of cycles with any stage held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 16'h0000;
        end else if ((stall != 6'b000000) && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Vector-table bench for pipe_stall_ctrl with a scoreboard queue.
// Built with TIMEOUT_CYCLES=4; STALL_PERF_EN enables counter checks.
module tb_pipe_stall_ctrl;

    localparam logic [5:0] S0 = 6'b000000;
    localparam logic [5:0] SI = 6'b000111;
    localparam logic [5:0] SE = 6'b001111;
    localparam logic [5:0] SM = 6'b011111;

`ifdef STALL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic       r;
        logic       id;
        logic       ex;
        logic       mem;
        logic       ack;
        logic [5:0] st;
        logic       br;
        logic       be;
    } vec_t;

    typedef struct {
        logic [5:0]  st;
        logic        br;
        logic        be;
        logic [15:0] cnt;
        int          idx;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        mem_req;
    logic        bus_ack;
    logic        bus_req;
    logic        bus_err;
    logic [5:0]  stall;
    logic [15:0] stall_cnt;

    vec_t        vecs[$];
    exp_t        sb[$];
    logic [15:0] model_cnt;
    int          checks;
    int          passed;

    pipe_stall_ctrl #(.TIMEOUT_CYCLES(8'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex),
        .mem_req    (mem_req),
        .bus_ack    (bus_ack),
        .bus_req    (bus_req),
        .bus_err    (bus_err),
        .stall      (stall),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t V(logic r, logic id, logic ex, logic mem,
                               logic ack, logic [5:0] st, logic br,
                               logic be);
        vec_t v;
        v.r   = r;
        v.id  = id;
        v.ex  = ex;
        v.mem = mem;
        v.ack = ack;
        v.st  = st;
        v.br  = br;
        v.be  = be;
        return v;
    endfunction

    task automatic check(input string nm, input int idx,
                         input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got === want) begin
            passed++;
        end else begin
            $display("FAIL %s vec %0d: got %h want %h", nm, idx, got, want);
        end
    endtask

    // Apply one cycle of stimulus; optionally queue its expected outputs.
    task automatic drive(input vec_t v, input int idx, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = v.r;
        stallreq_id = v.id;
        stallreq_ex = v.ex;
        mem_req     = v.mem;
        bus_ack     = v.ack;
        e.st  = v.st;
        e.br  = v.br;
        e.be  = v.be;
        e.cnt = PERF ? model_cnt : 16'h0000;
        e.idx = idx;
        if (chk) sb.push_back(e);
        if (!v.r) model_cnt = 16'h0000;
        else if (v.st != S0 && model_cnt != 16'hFFFF) model_cnt++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("stall", e.idx, {10'd0, stall}, {10'd0, e.st});
            check("bus_req", e.idx, {15'd0, bus_req}, {15'd0, e.br});
            check("bus_err", e.idx, {15'd0, bus_err}, {15'd0, e.be});
            check("stall_cnt", e.idx, stall_cnt, e.cnt);
        end
    end

    initial begin
        checks      = 0;
        passed      = 0;
        model_cnt   = 16'h0000;
        rst         = 1'b0;
        stallreq_id = 1'b0;
        stallreq_ex = 1'b0;
        mem_req     = 1'b0;
        bus_ack     = 1'b0;

        //                r  id ex mem ack stall br be
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 0));
        vecs.push_back(V(1, 1, 0, 0, 0, SI, 0, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 0));
        vecs.push_back(V(1, 0, 1, 0, 0, SE, 0, 0));
        vecs.push_back(V(1, 1, 1, 0, 0, SE, 0, 0));
        // load, ack on the third wait cycle
        vecs.push_back(V(1, 0, 0, 1, 0, SM, 0, 0));
        vecs.push_back(V(1, 0, 0, 1, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 1, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 1, 1, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 1, 1, S0, 0, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 0));
        // all requests together, ex held into MEM_DONE
        vecs.push_back(V(1, 1, 1, 1, 0, SM, 0, 0));
        vecs.push_back(V(1, 1, 1, 1, 1, SM, 1, 0));
        vecs.push_back(V(1, 0, 1, 0, 0, SE, 0, 0));
        vecs.push_back(V(1, 0, 1, 0, 0, SE, 0, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 0));
        // stray ack in RUN
        vecs.push_back(V(1, 0, 0, 0, 1, S0, 0, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 0));
        // timeout after four wait cycles
        vecs.push_back(V(1, 0, 0, 1, 0, SM, 0, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 1, 0, 0, SM, 1, 0));
        vecs.push_back(V(1, 1, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 1));
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 0));
        // ack on the last cycle before timeout wins
        vecs.push_back(V(1, 0, 0, 1, 0, SM, 0, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 1, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 0));
        // back-to-back loads; wait counter restarts from zero
        vecs.push_back(V(1, 0, 0, 1, 0, SM, 0, 0));
        vecs.push_back(V(1, 0, 0, 1, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 1, 1, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 1, 0, S0, 0, 0));
        vecs.push_back(V(1, 0, 0, 1, 0, SM, 0, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 1));
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 0));
        // reset during MEM_WAIT
        vecs.push_back(V(1, 0, 0, 1, 0, SM, 0, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(0, 0, 1, 1, 0, S0, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 0));
        // reset on the cycle that would otherwise time out
        vecs.push_back(V(1, 0, 0, 1, 0, SM, 0, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, SM, 1, 0));
        vecs.push_back(V(0, 0, 0, 0, 0, S0, 1, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 0));
        vecs.push_back(V(1, 1, 0, 0, 0, SI, 0, 0));
        vecs.push_back(V(1, 0, 0, 0, 0, S0, 0, 0));

        repeat (2) @(posedge clk);

        foreach (vecs[i]) drive(vecs[i], i, 1'b1);

        // counter: reset, ten stall cycles, then observe
        drive(V(0, 0, 0, 0, 0, S0, 0, 0), 100, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(V(1, 1, 0, 0, 0, SI, 0, 0), 101 + i, 1'b1);
        end
        drive(V(1, 0, 0, 0, 0, S0, 0, 0), 111, 1'b1);

`ifdef STALL_PERF_EN
        for (int i = 0; i < 65530; i++) begin
            drive(V(1, 1, 0, 0, 0, SI, 0, 0), 200, 1'b0);
        end
        drive(V(1, 1, 0, 0, 0, SI, 0, 0), 201, 1'b1);
        drive(V(1, 1, 0, 0, 0, SI, 0, 0), 202, 1'b1);
        drive(V(1, 0, 0, 0, 0, S0, 0, 0), 203, 1'b1);
`endif

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        check("drain", 0, 16'(sb.size()), 16'h0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
